comparator_result_filter: RTL
=============================

// Module: comparator_result_filter
//
// PURPOSE
// Sequential stage downstream of the 2-bit magnitude comparator. It consumes the {x,y,z} result
// (greater/equal/less) and publishes it only after it holds steady for STABLE_CYCLES samples.
// It flags any code that is not one-hot and counts published result changes.
// Its outputs drive LEDs/status logic, so switch-bounce glitches on {a,b,c,d} never reach them.
//
// PARAMETERS
// STABLE_CYCLES  4  consecutive identical legal samples required to publish (>=1)
// COUNT_WIDTH    8  width of change_count (>=1)
//
// PORTS
// clock         input   1            system clock, rising edge
// reset_n       input   1            synchronous active-low reset
// x             input   1            comparator "greater" result
// y             input   1            comparator "equal" result
// z             input   1            comparator "less" result
// clear         input   1            synchronous clear of error, counter and FSM
// gt            output  1            published greater, registered
// eq            output  1            published equal, registered
// lt            output  1            published less, registered
// stable        output  1            1 while in STABLE (published value is current)
// error         output  1            sticky: non-one-hot {x,y,z} sampled
// change_pulse  output  1            one-cycle pulse when a different code is published
// change_count  output  COUNT_WIDTH  published changes, saturating
//
// BEHAVIOUR
// - One clock, reset synchronous active-low. Priority: reset_n=0 > clear=1 > FSM.
// - Reset and clear give the same result:
//   - state=IDLE; gt/eq/lt/stable/error/change_pulse/change_count=0.
//   - Internal cand=0, cnt=0, pub_valid=0.
// - Every edge samples c={x,y,z}. c is legal iff exactly one bit is set.
// - From any state except FAULT, an illegal c causes the following at that edge:
//   - state=FAULT, error=1.
//   - gt/eq/lt=0, stable=0, pub_valid=0.
// - FAULT: all inputs except reset_n/clear ignored. error stays 1 until clear; clear -> IDLE.
// - New legal code: in IDLE, or in SETTLE/STABLE when c differs from cand:
//   - cand<=c, cnt<=1.
//   - If STABLE_CYCLES==1, publish at this edge. Otherwise state=SETTLE, stable=0.
// - SETTLE with c==cand: cnt<=cnt+1. When cnt+1==STABLE_CYCLES, publish.
// - Publish actions:
//   - {gt,eq,lt}<=cand, stable<=1, state=STABLE.
//   - If !pub_valid or cand differs from the last published code: change_pulse=1 for exactly
//     one cycle, and change_count increments (saturating at all ones).
//   - pub_valid<=1.
// - STABLE with c==cand: hold; change_pulse=0.
// - Latency: a code first sampled at edge k is published at edge k+STABLE_CYCLES-1.
// - During SETTLE, gt/eq/lt hold the last published code (0 if none); only stable drops.
// - Re-qualifying the same code after a glitch re-publishes it with no pulse and no count.
// - cnt width is clog2(STABLE_CYCLES+1). cnt never exceeds STABLE_CYCLES.
// - clear and an illegal c in the same cycle: clear wins; c is evaluated again next edge.
//
// TESTING (STABLE_CYCLES=4, COUNT_WIDTH=8 unless noted)
// 1. Reset: reset_n=0 for 2 edges with {x,y,z}=100, then release.
//    -> all outputs 0 during reset; gt=1, stable=1 only at the 4th edge after release.
// 2. Hold 100 for 4 edges.
//    -> gt=1, stable=1, change_pulse=1 for 1 cycle, change_count=1.
//    Then 001 for 4 edges -> lt=1, gt=0, change_count=2.
// 3. Stable eq, apply 001 for 2 edges, then 010.
//    -> stable=0 from the 1st glitch edge; eq=1 throughout.
//    -> stable=1 again 4 edges after 010 returns; change_pulse=0, count unchanged.
// 4. Apply 110 for 1 edge, then legal codes for 10 edges.
//    -> error=1, gt/eq/lt=0, stable=0, held for all 10 edges.
//    clear=1 -> error=0, change_count=0, IDLE.
// 5. COUNT_WIDTH=2: alternate 100/001, each held 4 edges, 5 times.
//    -> change_count=1,2,3,3,3; change_pulse still fires on every change.
// 6. Reset mid-SETTLE after 2 matching samples of 010.
//    -> all outputs 0; 010 needs 4 fresh edges after release to publish.
//    STABLE_CYCLES=1: 010 publishes on the first edge.

Source files
------------

// File: rtl/comparator_result_filter.sv
// comparator_result_filter
// Debounces the {x,y,z} greater/equal/less code from the 2-bit magnitude
// comparator. A code is published on gt/eq/lt only after STABLE_CYCLES
// identical one-hot samples. Any non-one-hot sample latches a sticky error.
// Published changes are counted with a saturating counter.
module comparator_result_filter #(
  parameter int STABLE_CYCLES = 4,
  parameter int COUNT_WIDTH   = 8
) (
  input  logic                   clock,
  input  logic                   reset_n,
  input  logic                   x,
  input  logic                   y,
  input  logic                   z,
  input  logic                   clear,
  output logic                   gt,
  output logic                   eq,
  output logic                   lt,
  output logic                   stable,
  output logic                   error,
  output logic                   change_pulse,
  output logic [COUNT_WIDTH-1:0] change_count
);

  localparam int CNT_W = $clog2(STABLE_CYCLES + 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    STABLE = 2'd2,
    FAULT  = 2'd3
  } state_t;

  // A comparator result is meaningful only when exactly one flag is set.
  function automatic logic is_one_hot3(input logic [2:0] v);
    return (v == 3'b100) || (v == 3'b010) || (v == 3'b001);
  endfunction

  state_t                   state_q, state_d;
  logic [2:0]               cand_q, cand_d;
  logic [CNT_W-1:0]         cnt_q, cnt_d;
  logic                     pub_valid_q, pub_valid_d;
  logic [2:0]               pub_q, pub_d;
  logic                     stable_q, stable_d;
  logic                     error_q, error_d;
  logic                     pulse_q, pulse_d;
  logic [COUNT_WIDTH-1:0]   count_q, count_d;

  logic [2:0]               sample_s;
  logic                     legal_s;
  logic [CNT_W-1:0]         cnt_inc_s;
  logic                     publish_s;

  assign sample_s  = {x, y, z};
  assign legal_s   = is_one_hot3(sample_s);
  assign cnt_inc_s = cnt_q + CNT_W'(1);

  // Next-state and next-output logic; clear behaves exactly like reset.
  always_comb begin
    state_d     = state_q;
    cand_d      = cand_q;
    cnt_d       = cnt_q;
    pub_valid_d = pub_valid_q;
    pub_d       = pub_q;
    stable_d    = stable_q;
    error_d     = error_q;
    pulse_d     = 1'b0;
    count_d     = count_q;
    publish_s   = 1'b0;

    if (clear) begin
      state_d     = IDLE;
      cand_d      = 3'b000;
      cnt_d       = '0;
      pub_valid_d = 1'b0;
      pub_d       = 3'b000;
      stable_d    = 1'b0;
      error_d     = 1'b0;
      count_d     = '0;
    end else begin
      case (state_q)
        FAULT: begin
          // Only reset or clear leave FAULT; samples are ignored here.
          state_d = FAULT;
        end
        IDLE, SETTLE, STABLE: begin
          if (!legal_s) begin
            state_d     = FAULT;
            error_d     = 1'b1;
            pub_d       = 3'b000;
            stable_d    = 1'b0;
            pub_valid_d = 1'b0;
            cnt_d       = '0;
          end else if ((state_q == IDLE) || (sample_s != cand_q)) begin
            // A new candidate restarts qualification; outputs keep the
            // last published code while it settles.
            cand_d = sample_s;
            cnt_d  = CNT_W'(1);
            if (STABLE_CYCLES == 1) begin
              publish_s = 1'b1;
            end else begin
              state_d  = SETTLE;
              stable_d = 1'b0;
            end
          end else if (state_q == SETTLE) begin
            cnt_d = cnt_inc_s;
            if (cnt_inc_s == CNT_W'(STABLE_CYCLES)) begin
              publish_s = 1'b1;
            end else begin
              state_d = SETTLE;
            end
          end else begin
            state_d = STABLE;
          end
        end
        default: begin
          state_d = FAULT;
          error_d = 1'b1;
        end
      endcase

      if (publish_s) begin
        pub_d       = cand_d;
        stable_d    = 1'b1;
        state_d     = STABLE;
        pub_valid_d = 1'b1;
        // Re-qualifying the same code after a glitch is not a change.
        if (!pub_valid_q || (cand_d != pub_q)) begin
          pulse_d = 1'b1;
          if (&count_q) begin
            count_d = count_q;
          end else begin
            count_d = count_q + COUNT_WIDTH'(1);
          end
        end else begin
          pulse_d = 1'b0;
        end
      end else begin
        pulse_d = 1'b0;
      end
    end
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      cand_q      <= 3'b000;
      cnt_q       <= '0;
      pub_valid_q <= 1'b0;
      pub_q       <= 3'b000;
      stable_q    <= 1'b0;
      error_q     <= 1'b0;
      pulse_q     <= 1'b0;
      count_q     <= '0;
    end else begin
      state_q     <= state_d;
      cand_q      <= cand_d;
      cnt_q       <= cnt_d;
      pub_valid_q <= pub_valid_d;
      pub_q       <= pub_d;
      stable_q    <= stable_d;
      error_q     <= error_d;
      pulse_q     <= pulse_d;
      count_q     <= count_d;
    end
  end

  assign gt           = pub_q[2];
  assign eq           = pub_q[1];
  assign lt           = pub_q[0];
  assign stable       = stable_q;
  assign error        = error_q;
  assign change_pulse = pulse_q;
  assign change_count = count_q;

endmodule
